// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared types and constants for the 4x4 matrix keypad scanner:
//   state_t    - scanner FSM states
//   COL_RESET  - column drive after reset (column 0 low)
//   KEY_MAP    - hex code for each key, indexed by {row, col}
//   first_low  - index of the lowest active-low bit in a 4-bit vector
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Row-major: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // Scans from the top down so the lowest low index wins.
    function automatic logic [1:0] first_low(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
// Bundles the keypad matrix lines and the decoded-key outputs.
//   rows      - row lines from the keypad, active-low
//   cols      - column drive, active-low, one bit low at a time
//   key_code  - hex code of the last accepted key
//   key_valid - one-cycle strobe per accepted key
//   value     - 16-bit entry register, newest digit in [3:0]
// master: the scanner; slave: keypad plus downstream consumer.
interface keypad_scanner_if;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] value;

    modport master (input rows, output cols, output key_code, output key_valid, output value);
    modport slave  (output rows, input cols, input key_code, input key_valid, input value);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a bus of independent asynchronous bits.
//   clk   - destination clock
//   reset - synchronous, active-high; loads RST_VAL into both stages
//   d     - asynchronous input
//   q     - synchronized output, two cycles behind d
module sync_2ff #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces
// press and release, and emits one strobe per accepted key.
//   clk   - system clock
//   reset - synchronous, active-high
//   kp    - keypad_scanner_if.master (rows in; cols, key_code,
//           key_valid, value out)
// Parameters: SCAN_DIV (cycles per column), DEBOUNCE_SCANS (matching
// samples to accept a press or a release).
// Macro KEYPAD_ENTRY_EN: builds the 16-bit entry shift register; when
// undefined, value is tied to zero.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 10000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scanner_if.master  kp
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(DEBOUNCE_SCANS - 1);

    logic [3:0]    rows_s;
    logic [DW-1:0] dwell_cnt;
    logic          sample;
    state_t        state, state_nxt;
    logic [3:0]    cols_q;
    logic [3:0]    row_lat;
    logic [MW-1:0] match_cnt;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          rows_idle, rows_match, cnt_last;
    logic          rotate, latch, emit, cnt_inc, cnt_clr;
    logic [3:0]    code;

    sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.rows),
        .q     (rows_s)
    );

    always_ff @(posedge clk) begin
        if (reset || dwell_cnt == DWELL_LAST) dwell_cnt <= '0;
        else                                  dwell_cnt <= dwell_cnt + 1'b1;
    end

    assign sample     = (dwell_cnt == DWELL_LAST);
    assign rows_idle  = &rows_s;
    assign rows_match = (rows_s == row_lat);
    assign cnt_last   = (match_cnt == MATCH_LAST);
    assign code       = KEY_MAP[{first_low(row_lat), first_low(cols_q)}];

    always_ff @(posedge clk) begin
        if (reset) state <= SCAN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sample) begin
            case (state)
                SCAN:     if (!rows_idle) state_nxt = DEBOUNCE;
                DEBOUNCE: if (!rows_match)   state_nxt = SCAN;
                          else if (cnt_last) state_nxt = HELD;
                HELD:     if (rows_idle && cnt_last) state_nxt = SCAN;
                default:  state_nxt = SCAN;
            endcase
        end
    end

    // match_cnt counts matching press samples in DEBOUNCE and
    // consecutive all-high samples in HELD.
    always_comb begin
        rotate  = 1'b0;
        latch   = 1'b0;
        emit    = 1'b0;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (rows_idle) rotate = 1'b1;
                    else begin
                        latch   = 1'b1;
                        cnt_clr = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!rows_match) rotate = 1'b1;
                    else if (cnt_last) begin
                        emit    = 1'b1;
                        cnt_clr = 1'b1;
                    end else cnt_inc = 1'b1;
                end
                HELD: begin
                    if (!rows_idle) cnt_clr = 1'b1;
                    else if (cnt_last) begin
                        rotate  = 1'b1;
                        cnt_clr = 1'b1;
                    end else cnt_inc = 1'b1;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cols_q      <= COL_RESET;
            row_lat     <= 4'hF;
            match_cnt   <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= emit;
            if (rotate)       cols_q    <= {cols_q[2:0], cols_q[3]};
            if (latch)        row_lat   <= rows_s;
            if (cnt_clr)      match_cnt <= '0;
            else if (cnt_inc) match_cnt <= match_cnt + 1'b1;
            if (emit)         key_code_q <= code;
        end
    end

`ifdef KEYPAD_ENTRY_EN
    logic [15:0] value_q;
    always_ff @(posedge clk) begin
        if (reset)     value_q <= 16'h0000;
        else if (emit) value_q <= {value_q[11:0], code};
    end
    assign kp.value = value_q;
`else
    assign kp.value = 16'h0000;
`endif

    assign kp.cols      = cols_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    keypad_scanner_if kif();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    // Keypad model: a pressed key pulls its row low while its column is driven low.
    logic [15:0] pressed;
    logic [3:0]  rows_m;
    always_comb begin
        rows_m = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.cols[c]) rows_m[r] = 1'b0;
    end
    assign kif.rows = rows_m;

    typedef struct { logic [3:0] code; logic [15:0] val; } exp_t;
    exp_t exp_q[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int pulse_cnt = 0, last_pulse_cyc = 0;
    int pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] ev(input logic [15:0] v);
`ifdef KEYPAD_ENTRY_EN
        return v;
`else
        return 16'h0000 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            exp_t e;
            pulse_cnt++;
            last_pulse_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: key_code %h value %h at cycle %0d, expected none",
                         kif.key_code, kif.value, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_key_code", {12'h0, kif.key_code}, {12'h0, e.code});
                check("pulse_value", kif.value, e.val);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cols_enter(input logic [3:0] target, output int t, output bit ok);
        int n;
        ok = 1'b0;
        t = 0;
        n = 0;
        while (kif.cols === target && n < 40) begin step(); n++; end
        n = 0;
        while (kif.cols !== target && n < 40) begin step(); n++; end
        if (kif.cols === target) begin ok = 1'b1; t = cyc; end
    endtask

    task automatic wait_pulse(input int prev, output bit ok);
        int n;
        n = 0;
        while (pulse_cnt == prev && n < 200) begin step(); n++; end
        ok = (pulse_cnt != prev);
    endtask

    task automatic expect_key(input logic [3:0] code, input logic [15:0] val);
        exp_t e;
        e.code = code;
        e.val  = val;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic press(input string name, input logic [15:0] mask, input logic [3:0] code,
                         input logic [15:0] val, input int hold);
        int prev;
        bit ok;
        prev = pulse_cnt;
        expect_key(code, val);
        pressed = mask;
        wait_pulse(prev, ok);
        if (!ok) begin
            timeout(name);
            void'(exp_q.pop_back());
            pushed--;
        end
        repeat (hold) step();
        pressed = 16'h0;
        repeat (20) step();
    endtask

    localparam logic [3:0] COLSEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        int t_col, t_n;
        bit ok;
        int prev;

        reset   = 1'b1;
        pressed = 16'h0;

        // Reset state and idle column rotation
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_cols", {12'h0, kif.cols}, 16'h000E);
        check("reset_value", kif.value, 16'h0000);
        check("reset_key_valid", {15'h0, kif.key_valid}, 16'h0000);
        check("reset_key_code", {12'h0, kif.key_code}, 16'h0000);
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("idle_rotation", {12'h0, kif.cols}, {12'h0, COLSEQ[(i/4)%4]});
        end

        // Single press "6" with latency measured from entry of column 2
        wait_cols_enter(4'b1110, t_n, ok);
        if (!ok) timeout("wait_c0_for_6");
        prev = pulse_cnt;
        expect_key(4'h6, ev(16'h0006));
        pressed = 16'h0040;
        wait_cols_enter(4'b1011, t_col, ok);
        if (!ok) timeout("wait_c2_for_6");
        wait_pulse(prev, ok);
        if (!ok) timeout("pulse_6");
        else check("press_latency", 16'(last_pulse_cyc - t_col), 16'd12);
        repeat (30) step();
        pressed = 16'h0;
        repeat (20) step();
        check("single_press_count", 16'(pulse_cnt), 16'd1);

        // Entry shift 1, 2, A, F then 3
        press("key_1", 16'h0001, 4'h1, ev(16'h0061), 5);
        press("key_2", 16'h0002, 4'h2, ev(16'h0612), 5);
        press("key_A", 16'h0008, 4'hA, ev(16'h612A), 5);
        press("key_F", 16'h2000, 4'hF, ev(16'h12AF), 5);
        check("entry_12AF", kif.value, ev(16'h12AF));
        press("key_3", 16'h0004, 4'h3, ev(16'h2AF3), 5);
        check("entry_2AF3", kif.value, ev(16'h2AF3));

        // Bounce: one matching sample only, then release
        wait_cols_enter(4'b1110, t_n, ok);
        if (!ok) timeout("wait_c0_bounce");
        prev = pulse_cnt;
        pressed = 16'h0001;
        repeat (4) step();
        pressed = 16'h0;
        repeat (3) step();
        check("bounce_col_held", {12'h0, kif.cols}, 16'h000E);
        step();
        check("bounce_col_next", {12'h0, kif.cols}, 16'h000D);
        repeat (20) step();
        check("bounce_no_pulse", 16'(pulse_cnt - prev), 16'd0);

        // Long hold and multi-key priority
        prev = pulse_cnt;
        press("hold_5", 16'h0020, 4'h5, ev(16'hAF35), 100);
        check("hold_one_pulse", 16'(pulse_cnt - prev), 16'd1);
        press("multi_7", 16'h1100, 4'h7, ev(16'hF357), 10);

        // Reset in the middle of a debounce
        wait_cols_enter(4'b1101, t_n, ok);
        if (!ok) timeout("wait_c1_reset");
        prev = pulse_cnt;
        pressed = 16'h0002;
        repeat (6) step();
        reset = 1'b1;
        step();
        check("midreset_cols", {12'h0, kif.cols}, 16'h000E);
        check("midreset_key_valid", {15'h0, kif.key_valid}, 16'h0000);
        check("midreset_key_code", {12'h0, kif.key_code}, 16'h0000);
        check("midreset_value", kif.value, 16'h0000);
        pressed = 16'h0;
        repeat (2) step();
        reset = 1'b0;
        repeat (30) step();
        check("midreset_no_pulse", 16'(pulse_cnt - prev), 16'd0);
        check("midreset_value_hold", kif.value, 16'h0000);

        check("total_pulses", 16'(pulse_cnt), 16'(pushed));
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix hex keypad (PmodKYPD-style) by driving one column low at a time and sampling the row lines, then debounces and decodes each press into a 4-bit hex code. It is the input-side counterpart of the board's multiplexed seven-segment display path: it scans a matrix instead of driving one. Each accepted key is emitted as a one-cycle strobe and shifted into a 16-bit entry register that can feed the display driver directly.

## Interface
- SCAN_DIV, 10000: clock cycles each column is driven before its rows are sampled (dwell).
- DEBOUNCE_SCANS, 4: consecutive matching samples required to accept a press or a release.
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- rows  input  4  keypad row lines, active-low (external pull-ups); asynchronous to clk.
- cols  output  4  column drive, active-low, exactly one bit low at all times.
- key_code  output  4  hex code of the most recently accepted key.
- key_valid  output  1  one-cycle pulse when a key is accepted.
- value  output  16  entry register; newest digit in [3:0].

## Operation
- rows pass through a 2-flop synchronizer before any use.
- A dwell counter counts 0..SCAN_DIV-1 and wraps. A "sample" is the cycle the counter equals SCAN_DIV-1.
- Key map (row r, column c driven low): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: 0 F E D, with c0 leftmost.
- If several rows are low, the lowest-index row wins.
- State machine:
  - SCAN: at each sample, if all synchronized rows are high, rotate cols left (1110→1101→1011→0111→1110). Otherwise latch the row pattern, hold the column, clear the match count, and go to DEBOUNCE.
  - DEBOUNCE: at each sample, compare the rows with the latched pattern.
    - On a match, increment the match count. When it reaches DEBOUNCE_SCANS, emit the key and go to HELD.
    - On a mismatch, return to SCAN and rotate the column.
  - HELD: the column stays held. At each sample, count consecutive all-high samples (reset the count on any low). When the count reaches DEBOUNCE_SCANS, rotate the column and go to SCAN.
- Emit: key_valid=1 for one cycle; key_code updates to the decoded code; value <= {value[11:0], code}, the oldest digit is discarded.
- A key held indefinitely produces exactly one key_valid (no auto-repeat).
- reset asserted in any state returns the block to its reset values on the next clock edge. A pending debounce is discarded.

## Timing
- Reset values: cols=4'b1110, key_code=0, key_valid=0, value=16'h0000, state SCAN, all counters 0.
- Synchronizer latency: 2 cycles from a rows pin change to its visibility.
- Press latency: key_valid rises in the cycle after the DEBOUNCE_SCANS-th matching sample following the detecting sample. This is DEBOUNCE_SCANS*SCAN_DIV+1 cycles after detection.
- key_code and value change in the same cycle key_valid is high, and hold until the next emit.
- Column changes occur only in the cycle after a sample. The column dwell is always SCAN_DIV cycles.
- Worst-case detection delay for a stable press: 4*SCAN_DIV cycles plus 2 (synchronizer).

## Configuration
- KEYPAD_ENTRY_EN defined: the 16-bit value shift register is built as described.
- KEYPAD_ENTRY_EN not defined: no entry register is generated and value is tied to 16'h0000. key_code and key_valid are unaffected.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD);
  - the 16-entry key-map constant indexed by {row, col};
  - the column reset constant 4'b1110.
- One sub-module is natural: sync_2ff, a parameterized-width 2-flop synchronizer used for rows.
- The rest is one module: dwell counter, FSM, decode, and entry register.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2.
- Reset: hold reset 3 cycles → cols=1110, value=0000, key_valid=0. Release with no key → cols steps 1110→1101→1011→0111→1110, one step every 4 cycles.
- Single press: press r1,c2 ("6") until released → exactly one key_valid pulse, 9 cycles after the detecting sample; key_code=6; value=0006.
- Entry shift: press and release 1, 2, A, F in turn (each after a full release) → value=12AF. Then press 3 → value=2AF3.
- Bounce: assert r0 for fewer than 2 matching samples, then release → no key_valid; scan resumes with the next column.
- Hold and multi-key: hold "5" for 100 cycles → one pulse only. Press r2 and r3 on c0 simultaneously → key_code=7.
- Mid-debounce reset: assert reset while in DEBOUNCE → no pulse; outputs at reset values. With KEYPAD_ENTRY_EN undefined, value stays 0000 throughout.
